mem_line_ctrl: RTL and testbench

- Main-memory line controller directly downstream of the instruction and data caches.
- Serves three requesters over one line-wide memory array with fixed access latency:
  - instruction-cache line fill
  - data-cache line fill
  - data-cache dirty-line write-back
- Arbitrates between requesters, runs one access at a time, and returns a one-cycle valid/ack pulse to the requester it served.

---
 rtl/mem_line_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_line_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: main-memory line controller behind the instruction and data
// caches. It arbitrates between the icache fill, the dcache fill and the
// dcache write-back. It runs one fixed-latency access at a time against a
// line-wide array. The requester it served gets a one-cycle valid/ack pulse.
// The array starts undefined; a line must be written before it is read.
module mem_line_ctrl #(
  parameter int ARCH_BITS = 32,
  parameter int LINE_BITS = 128,
  parameter int IDX_BITS  = 12,
  parameter int LATENCY   = 10,
  parameter     INIT_FILE = "memory.hex"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ARCH_BITS-1:0] iReadAddr,
  input  logic                 iReadReq,
  output logic [LINE_BITS-1:0] iReadData,
  output logic                 iReadValid,
  input  logic [ARCH_BITS-1:0] dReadAddr,
  input  logic                 dReadReq,
  output logic [LINE_BITS-1:0] dReadData,
  output logic                 dReadValid,
  input  logic [ARCH_BITS-1:0] dWriteAddr,
  input  logic [LINE_BITS-1:0] dWriteLine,
  input  logic                 dWriteReq,
  output logic                 dWriteAck,
  output logic                 busy
);

  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int DEPTH    = 1 << IDX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  typedef enum logic [1:0] {OP_IRD, OP_DRD, OP_WR} op_e;

  // NOTE: the line array has no reset; contents must survive rst, and a reset
  // loop over every line would not map onto a RAM macro.
  logic [LINE_BITS-1:0] mem [DEPTH];

  localparam int unused_init_file_bits = $bits(INIT_FILE);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 last_d_q, last_d_d;   // 1: dcache read was the last read served
  op_e                  op_q, op_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [LINE_BITS-1:0] i_data_q, d_data_q;
  logic                 i_valid_q, d_valid_q, w_ack_q, busy_q;

  // Grant candidate and commit controls
  op_e                  gnt_op;
  logic [IDX_BITS-1:0]  gnt_idx;
  logic                 any_req;
  logic                 commit;
  op_e                  cm_op;
  logic [IDX_BITS-1:0]  cm_idx;
  logic [LINE_BITS-1:0] cm_line;

  // Offset and upper address bits are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iReadAddr[ARCH_BITS-1:OFF_BITS+IDX_BITS], iReadAddr[OFF_BITS-1:0],
                              dReadAddr[ARCH_BITS-1:OFF_BITS+IDX_BITS], dReadAddr[OFF_BITS-1:0],
                              dWriteAddr[ARCH_BITS-1:OFF_BITS+IDX_BITS], dWriteAddr[OFF_BITS-1:0]};

  // Arbitration: write-back first, then round-robin between the two fills.
  always_comb begin
    any_req = dWriteReq | dReadReq | iReadReq;
    gnt_op  = OP_IRD;
    gnt_idx = iReadAddr[OFF_BITS+IDX_BITS-1:OFF_BITS];
    if (dWriteReq) begin
      gnt_op  = OP_WR;
      gnt_idx = dWriteAddr[OFF_BITS+IDX_BITS-1:OFF_BITS];
    end else if (dReadReq && (!iReadReq || !last_d_q)) begin
      gnt_op  = OP_DRD;
      gnt_idx = dReadAddr[OFF_BITS+IDX_BITS-1:OFF_BITS];
    end
  end

  // Next-state logic: IDLE grants, BUSY counts down, RESP lasts one cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d_d = last_d_q;
    op_d     = op_q;
    idx_d    = idx_q;
    line_d   = line_q;
    commit   = 1'b0;
    cm_op    = op_q;
    cm_idx   = idx_q;
    cm_line  = line_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          op_d   = gnt_op;
          idx_d  = gnt_idx;
          line_d = dWriteLine;
          if (gnt_op != OP_WR) last_d_d = (gnt_op == OP_DRD);
          if (LATENCY == 1) begin
            // Single-cycle access commits on the grant edge itself.
            state_d = S_RESP;
            commit  = 1'b1;
            cm_op   = gnt_op;
            cm_idx  = gnt_idx;
            cm_line = dWriteLine;
          end else begin
            state_d = S_BUSY;
            cnt_d   = 8'(LATENCY - 1);
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b0;
      op_q      <= OP_IRD;
      idx_q     <= '0;
      line_q    <= '0;
      i_data_q  <= '0;
      d_data_q  <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      w_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      line_q    <= line_d;
      // A read whose request dropped still loads its data but does not pulse.
      i_valid_q <= commit && (cm_op == OP_IRD) && iReadReq;
      d_valid_q <= commit && (cm_op == OP_DRD) && dReadReq;
      w_ack_q   <= commit && (cm_op == OP_WR);
      busy_q    <= (state_d != S_IDLE);
      if (commit && cm_op == OP_IRD) i_data_q <= mem[cm_idx];
      if (commit && cm_op == OP_DRD) d_data_q <= mem[cm_idx];
    end
  end

  // Array write port; a write cut off by reset never lands.
  always_ff @(posedge clk) begin
    if (!rst && commit && cm_op == OP_WR) mem[cm_idx] <= cm_line;
  end

  assign iReadData  = i_data_q;
  assign dReadData  = d_data_q;
  assign iReadValid = i_valid_q;
  assign dReadValid = d_valid_q;
  assign dWriteAck  = w_ack_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Testbench for mem_line_ctrl: directed scenarios plus randomized request
// batches. Expected results come from a transaction-level model that tracks
// the line contents, the service order and the response times.
module tb_mem_line_ctrl;

  localparam int L = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [31:0]  iReadAddr = '0, dReadAddr = '0, dWriteAddr = '0;
  logic [127:0] dWriteLine = '0;
  logic         iReadReq = 1'b0, dReadReq = 1'b0, dWriteReq = 1'b0;
  logic [127:0] iReadData, dReadData;
  logic         iReadValid, dReadValid, dWriteAck, busy;

  // Second instance for the single-cycle latency case
  logic [31:0]  s_iReadAddr = '0, s_dReadAddr = '0, s_dWriteAddr = '0;
  logic [127:0] s_dWriteLine = '0;
  logic         s_iReadReq = 1'b0, s_dReadReq = 1'b0, s_dWriteReq = 1'b0;
  logic [127:0] s_iReadData, s_dReadData;
  logic         s_iReadValid, s_dReadValid, s_dWriteAck, s_busy;

  mem_line_ctrl #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .iReadAddr(iReadAddr), .iReadReq(iReadReq), .iReadData(iReadData), .iReadValid(iReadValid),
    .dReadAddr(dReadAddr), .dReadReq(dReadReq), .dReadData(dReadData), .dReadValid(dReadValid),
    .dWriteAddr(dWriteAddr), .dWriteLine(dWriteLine), .dWriteReq(dWriteReq), .dWriteAck(dWriteAck),
    .busy(busy)
  );

  mem_line_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .iReadAddr(s_iReadAddr), .iReadReq(s_iReadReq), .iReadData(s_iReadData), .iReadValid(s_iReadValid),
    .dReadAddr(s_dReadAddr), .dReadReq(s_dReadReq), .dReadData(s_dReadData), .dReadValid(s_dReadValid),
    .dWriteAddr(s_dWriteAddr), .dWriteLine(s_dWriteLine), .dWriteReq(s_dWriteReq), .dWriteAck(s_dWriteAck),
    .busy(s_busy)
  );

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef enum int {K_WR, K_DRD, K_IRD} kind_e;

  // Reference model: line contents by index, and which read was served last.
  logic [127:0] mdl_mem [int];
  bit           mdl_last_d = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd4096);
  endfunction

  function automatic logic [31:0] mk_addr(input int idx, input bit aligned);
    logic [31:0] hi, off;
    hi  = 32'($urandom_range(0, 65535));
    off = aligned ? 32'd0 : 32'($urandom_range(0, 15));
    return (hi << 16) | (32'(idx) << 4) | off;
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Wait for the next pulse, check it, then drop the served request in RESP.
  task automatic wait_resp(input string tag, input kind_e kind, input int unsigned edge_exp,
                           input logic [127:0] data_exp);
    bit    seen = 1'b0;
    kind_e got;
    for (int c = 0; c < 4 * L + 40 && !seen; c++) begin
      @(negedge clk);
      if (iReadValid || dReadValid || dWriteAck) begin
        seen = 1'b1;
        check({tag, " onehot"}, 128'($countones({iReadValid, dReadValid, dWriteAck})), 128'd1);
        got = dWriteAck ? K_WR : (dReadValid ? K_DRD : K_IRD);
        check({tag, " kind"}, 128'(got), 128'(kind));
        check({tag, " latency"}, 128'(edge_n), 128'(edge_exp));
        check({tag, " busy"}, 128'(busy), 128'd1);
        if (got == K_DRD && kind == K_DRD) check({tag, " ddata"}, dReadData, data_exp);
        if (got == K_IRD && kind == K_IRD) check({tag, " idata"}, iReadData, data_exp);
        case (got)
          K_WR:    dWriteReq = 1'b0;
          K_DRD:   dReadReq  = 1'b0;
          default: iReadReq  = 1'b0;
        endcase
      end
    end
    if (!seen) check({tag, " timeout"}, 128'(seen), 128'd1);
  endtask

  // Raise a set of requests together from an idle cycle and check the lot.
  task automatic batch(input string tag, input bit w, input bit d, input bit i,
                       input logic [31:0] wa, input logic [31:0] da, input logic [31:0] ia,
                       input logic [127:0] wl);
    int unsigned  g;
    kind_e        order[$];
    logic [127:0] exp;
    dWriteAddr = wa; dWriteLine = wl; dWriteReq = w;
    dReadAddr  = da; dReadReq   = d;
    iReadAddr  = ia; iReadReq   = i;
    g = edge_n + 1;
    if (w) order.push_back(K_WR);
    if (d && i) begin
      if (mdl_last_d) begin order.push_back(K_IRD); order.push_back(K_DRD); end
      else            begin order.push_back(K_DRD); order.push_back(K_IRD); end
    end else if (d) order.push_back(K_DRD);
    else if (i)     order.push_back(K_IRD);
    foreach (order[k]) begin
      exp = '0;
      case (order[k])
        K_WR:    mdl_mem[idx_of(wa)] = wl;
        K_DRD:   begin exp = mdl_mem[idx_of(da)]; mdl_last_d = 1'b1; end
        default: begin exp = mdl_mem[idx_of(ia)]; mdl_last_d = 1'b0; end
      endcase
      wait_resp(tag, order[k], g + L - 1, exp);
      g = g + L + 1;
    end
    @(negedge clk);
    check({tag, " idle"}, 128'(busy), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dWriteReq = 1'b0; dReadReq = 1'b0; iReadReq = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", 128'(busy), 128'd0);
    check("rst pulses", 128'({iReadValid, dReadValid, dWriteAck}), 128'd0);
    check("rst idata", iReadData, 128'd0);
    check("rst ddata", dReadData, 128'd0);
    rst = 1'b0;
    mdl_last_d = 1'b0;
  endtask

  initial begin
    logic [127:0] line_a, old100, d0, d1;
    int unsigned  g;
    bit           any;

    line_a = 128'h11112222333344445555666677778888;
    do_reset();

    // Fill lines 0..16; line 4 (0x40) gets the known pattern.
    for (int idx = 0; idx <= 16; idx++)
      batch("init_wr", 1'b1, 1'b0, 1'b0, 32'(idx * 16), 32'd0, 32'd0,
            (idx == 4) ? line_a : rnd_line());
    old100 = mdl_mem[16];

    // Read-after-write through an unaligned address, then an aliased one.
    batch("rd_4c", 1'b0, 1'b1, 1'b0, 32'd0, 32'h4C, 32'd0, '0);
    batch("alias", 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h10040, '0);

    // Tie after reset: dcache first, icache next. The dcache re-request then
    // meets the pending icache.
    do_reset();
    @(negedge clk);
    dReadAddr = 32'h20; iReadAddr = 32'h30; dReadReq = 1'b1; iReadReq = 1'b1;
    g = edge_n + 1;
    wait_resp("tie d1", K_DRD, g + L - 1, mdl_mem[2]);
    dReadAddr = 32'h50; dReadReq = 1'b1;
    g = g + L + 1;
    wait_resp("tie i", K_IRD, g + L - 1, mdl_mem[3]);
    g = g + L + 1;
    wait_resp("tie d2", K_DRD, g + L - 1, mdl_mem[5]);
    mdl_last_d = 1'b1;
    @(negedge clk);

    // Write-back and fill of the same line arriving together.
    batch("wb_80", 1'b1, 1'b1, 1'b0, 32'h80, 32'h80, 32'd0, rnd_line());

    // Reset five cycles into a write to 0x100.
    dWriteAddr = 32'h100; dWriteLine = ~old100; dWriteReq = 1'b1;
    g = edge_n + 1;
    while (edge_n < g + 5) @(negedge clk);
    rst = 1'b1; dWriteReq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mdl_last_d = 1'b0;
    check("midrst busy", 128'(busy), 128'd0);
    check("midrst ack", 128'(dWriteAck), 128'd0);
    any = 1'b0;
    repeat (2 * L) begin
      @(negedge clk);
      any = any | dWriteAck;
    end
    check("midrst no ack", 128'(any), 128'd0);
    batch("midrst old", 1'b0, 1'b1, 1'b0, 32'd0, 32'h100, 32'd0, '0);

    // Randomized batches over aliased addresses.
    for (int n = 0; n < 40; n++) begin
      bit w, d, i;
      w = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      i = 1'($urandom_range(0, 1));
      if (!(w || d || i)) i = 1'b1;
      batch("rand", w, d, i, mk_addr($urandom_range(0, 16), 1'b1),
            mk_addr($urandom_range(0, 16), 1'b0), mk_addr($urandom_range(0, 16), 1'b0), rnd_line());
    end

    // Aborted icache read: no pulse, but the data register still loads.
    batch("pre_abort", 1'b1, 1'b0, 1'b0, 32'h50, 32'd0, 32'd0, rnd_line());
    batch("pre_abort_rd", 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h50, '0);
    batch("abort_line", 1'b1, 1'b0, 1'b0, 32'h30, 32'd0, 32'd0, rnd_line());
    iReadAddr = 32'h30; iReadReq = 1'b1;
    repeat (3) @(negedge clk);
    iReadReq = 1'b0;
    mdl_last_d = 1'b0;
    any = 1'b0;
    repeat (2 * L) begin
      @(negedge clk);
      any = any | iReadValid | dReadValid | dWriteAck;
    end
    check("abort no pulse", 128'(any), 128'd0);
    check("abort data", iReadData, mdl_mem[3]);
    batch("post_abort", 1'b0, 1'b1, 1'b1, 32'd0, 32'h40, 32'h80, '0);

    // Single-cycle latency instance: two writes, then back-to-back reads.
    d0 = rnd_line();
    d1 = rnd_line();
    for (int k = 0; k < 2; k++) begin
      s_dWriteAddr = 32'(k * 16); s_dWriteLine = (k == 0) ? d0 : d1; s_dWriteReq = 1'b1;
      @(negedge clk);
      check("l1 wr ack", 128'(s_dWriteAck), 128'd1);
      s_dWriteReq = 1'b0;
      @(negedge clk);
      check("l1 wr idle", 128'({s_busy, s_dWriteAck}), 128'd0);
    end
    s_iReadAddr = 32'h0; s_iReadReq = 1'b1;
    @(negedge clk);
    check("l1 rd0 valid", 128'({s_busy, s_iReadValid}), 128'd3);
    check("l1 rd0 data", s_iReadData, d0);
    s_iReadAddr = 32'h10;
    @(negedge clk);
    check("l1 gap", 128'({s_busy, s_iReadValid}), 128'd0);
    @(negedge clk);
    check("l1 rd1 valid", 128'({s_busy, s_iReadValid}), 128'd3);
    check("l1 rd1 data", s_iReadData, d1);
    s_iReadReq = 1'b0;
    @(negedge clk);
    check("l1 end", 128'({s_busy, s_iReadValid}), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
